// File: rtl/sr_mul_unit_if.sv
// Handshake/data bundle between the schoolRISCV decode/regfile stage and sr_mul_unit.
// The core drives the master side; the multiplier owns the slave side.
interface sr_mul_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic [WIDTH-1:0] result;
  logic             vld;
  logic             stall;
  logic             busy;

  modport master (
    output start, srcA, srcB,
    input  result, vld, stall, busy
  );

  modport slave (
    input  start, srcA, srcB,
    output result, vld, stall, busy
  );
endinterface

// File: rtl/sr_mul_unit.sv
// Iterative shift-add multiplier (low WIDTH bits of srcA*srcB) for the schoolRISCV core.
// Optional macro SR_MUL_EARLY_TERM_EN: leave BUSY as soon as the remaining multiplier is zero.
module sr_mul_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic          clk,
  input logic          rst_n,
  sr_mul_unit_if.slave mulIf
);

  localparam int ITER  = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT            stateReg,  stateNext;
  logic [WIDTH-1:0] accReg,    accNext;
  logic [WIDTH-1:0] mcandReg,  mcandNext;
  logic [WIDTH-1:0] mplierReg, mplierNext;
  logic [CNT_W-1:0] cntReg,    cntNext;
  logic [WIDTH-1:0] resultReg, resultNext;

  logic [WIDTH-1:0] partTerm [BITS_PER_CYCLE];
  logic [WIDTH-1:0] stepSum;
  logic [WIDTH-1:0] postShift;
  logic             lastStep;
  logic             vldInt;

  // One partial product per multiplier bit consumed this step; the sum is mcand*mplier[BPC-1:0].
  genvar gi;
  generate
    for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_part
      assign partTerm[gi] = mplierReg[gi] ? (mcandReg << gi) : '0;
    end
  endgenerate

  always_comb begin
    stepSum = accReg;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      stepSum = stepSum + partTerm[i];
    end
  end

  assign postShift = mplierReg >> BITS_PER_CYCLE;

`ifdef SR_MUL_EARLY_TERM_EN
  assign lastStep = (cntReg == CNT_W'(ITER - 1)) || (postShift == '0);
`else
  assign lastStep = (cntReg == CNT_W'(ITER - 1));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg  <= IDLE;
      accReg    <= '0;
      mcandReg  <= '0;
      mplierReg <= '0;
      cntReg    <= '0;
      resultReg <= '0;
    end else begin
      stateReg  <= stateNext;
      accReg    <= accNext;
      mcandReg  <= mcandNext;
      mplierReg <= mplierNext;
      cntReg    <= cntNext;
      resultReg <= resultNext;
    end
  end

  always_comb begin
    stateNext  = stateReg;
    accNext    = accReg;
    mcandNext  = mcandReg;
    mplierNext = mplierReg;
    cntNext    = cntReg;
    resultNext = resultReg;

    case (stateReg)
      IDLE: begin
        if (mulIf.start) begin
          mcandNext  = mulIf.srcA;
          mplierNext = mulIf.srcB;
          accNext    = '0;
          cntNext    = '0;
          stateNext  = BUSY;
        end
      end
      BUSY: begin
        accNext    = stepSum;
        mcandNext  = mcandReg << BITS_PER_CYCLE;
        mplierNext = postShift;
        cntNext    = cntReg + CNT_W'(1);
        // A dropped start means the instruction was squashed: discard the product silently.
        if (!mulIf.start) begin
          stateNext = IDLE;
        end else if (lastStep) begin
          resultNext = stepSum;
          stateNext  = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign vldInt       = (stateReg == DONE);
  assign mulIf.vld    = vldInt;
  assign mulIf.busy   = (stateReg != IDLE);
  assign mulIf.result = resultReg;
  // Gated by rst_n so a held start cannot freeze the PC while the core is in reset.
  assign mulIf.stall  = rst_n & mulIf.start & ~vldInt;

endmodule

// File: tb/tb_sr_mul_unit.sv
// Self-checking bench for sr_mul_unit: directed corner cases plus random operands,
// checked against plain 32-bit products and a latency formula.
module tb_sr_mul_unit;

  localparam int W    = 32;
  localparam int BPC  = 1;
  localparam int ITER = W / BPC;

  logic clk;
  logic rst_n;
  int   nTests;
  int   nFails;
  logic [W-1:0] lastRes;

  sr_mul_unit_if #(.WIDTH(W)) mif ();

  sr_mul_unit #(
    .WIDTH         (W),
    .BITS_PER_CYCLE(BPC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mulIf(mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Number of BUSY cycles a MUL with multiplier b should take.
  function automatic int expBusy(input logic [W-1:0] b);
`ifdef SR_MUL_EARLY_TERM_EN
    int top;
    top = 0;
    for (int i = 0; i < W; i++) if (b[i]) top = i + 1;
    if (top == 0) return 1;
    return (top + BPC - 1) / BPC;
`else
    return ITER;
`endif
  endfunction

  // Called just after a negedge; returns just after the negedge of the DONE cycle.
  task automatic runMul(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W-1:0] expRes;
    int  k;
    int  badBusy;
    bit  seen;
    expRes = a * b;
    mif.start = 1'b1;
    mif.srcA  = a;
    mif.srcB  = b;
    #1;
    checkVal({tag, "_launchStall"}, 32'(mif.stall), 32'd1);
    checkVal({tag, "_launchBusy"},  32'(mif.busy),  32'd0);
    checkVal({tag, "_launchVld"},   32'(mif.vld),   32'd0);
    k = 0;
    badBusy = 0;
    seen = 1'b0;
    while (!seen && k < ITER + 10) begin
      @(negedge clk);
      #1;
      k++;
      if (mif.vld) seen = 1'b1;
      else if (!mif.stall || !mif.busy || mif.result !== lastRes) badBusy++;
    end
    checkVal({tag, "_vldSeen"}, 32'(seen), 32'd1);
    checkVal({tag, "_busyCycles"}, 32'(badBusy), 32'd0);
    if (seen) begin
      checkVal({tag, "_latency"},   32'(k + 1), 32'(expBusy(b) + 2));
      checkVal({tag, "_result"},    mif.result, expRes);
      checkVal({tag, "_doneStall"}, 32'(mif.stall), 32'd0);
      checkVal({tag, "_doneBusy"},  32'(mif.busy),  32'd1);
      lastRes = expRes;
    end
    $display("[TB] %s: 0x%08h * 0x%08h -> 0x%08h (cycles %0d)", tag, a, b, mif.result, k + 1);
  endtask

  // Drop start after a MUL and confirm the single vld pulse and result hold.
  task automatic idleCheck(input string tag);
    @(negedge clk);
    mif.start = 1'b0;
    #1;
    checkVal({tag, "_idleVld"},    32'(mif.vld),   32'd0);
    checkVal({tag, "_idleBusy"},   32'(mif.busy),  32'd0);
    checkVal({tag, "_idleStall"},  32'(mif.stall), 32'd0);
    checkVal({tag, "_idleResult"}, mif.result, lastRes);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int vldHits;

    nTests  = 0;
    nFails  = 0;
    lastRes = '0;
    rst_n     = 1'b0;
    mif.start = 1'b1;
    mif.srcA  = 32'd3;
    mif.srcB  = 32'd5;

    // Reset held with start high.
    repeat (2) begin
      @(negedge clk);
      #1;
      checkVal("rst_vld",    32'(mif.vld),   32'd0);
      checkVal("rst_busy",   32'(mif.busy),  32'd0);
      checkVal("rst_result", mif.result,     32'd0);
      checkVal("rst_stall",  32'(mif.stall), 32'd0);
    end
    $display("[TB] reset checked");

    @(negedge clk);
    rst_n = 1'b1;
    runMul(32'd3, 32'd5, "mul3x5");
    idleCheck("mul3x5");

    @(negedge clk);
    runMul(32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulAllOnes");
    idleCheck("mulAllOnes");

    @(negedge clk);
    runMul(32'h8000_0000, 32'd2, "mulTrunc");
    idleCheck("mulTrunc");

    // Back-to-back with start continuously high.
    @(negedge clk);
    runMul(32'd7, 32'd6, "b2bFirst");
    @(negedge clk);
    runMul(32'd9, 32'd9, "b2bSecond");
    idleCheck("b2bSecond");

    // Random operands, including an occasional zero multiplier.
    for (int t = 0; t < 8; t++) begin
      ra = $urandom;
      rb = $urandom;
      if (t == 3) rb = '0;
      if (t == 5) rb = rb >> $urandom_range(31, 1);
      @(negedge clk);
      runMul(ra, rb, $sformatf("rand%0d", t));
      idleCheck($sformatf("rand%0d", t));
    end

    // Abort: start dropped after 10 BUSY cycles.
    @(negedge clk);
    mif.start = 1'b1;
    mif.srcA  = $urandom;
    mif.srcB  = $urandom | 32'h8000_0001;
    repeat (11) @(negedge clk);
    mif.start = 1'b0;
    #1;
    checkVal("abort_stallDrop", 32'(mif.stall), 32'd0);
    vldHits = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (mif.vld) vldHits++;
    end
    checkVal("abort_busy",   32'(mif.busy), 32'd0);
    checkVal("abort_noVld",  32'(vldHits),  32'd0);
    checkVal("abort_result", mif.result,    lastRes);
    $display("[TB] abort: busy=%0d vldHits=%0d result=0x%08h", mif.busy, vldHits, mif.result);

    // Reset during BUSY cycle 5.
    @(negedge clk);
    mif.start = 1'b1;
    mif.srcA  = 32'h1234_5678;
    mif.srcB  = 32'h8000_0003;
    repeat (5) @(negedge clk);
    #1;
    checkVal("midRst_busyBefore", 32'(mif.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkVal("midRst_stall", 32'(mif.stall), 32'd0);
    @(negedge clk);
    #1;
    checkVal("midRst_busy",   32'(mif.busy), 32'd0);
    checkVal("midRst_vld",    32'(mif.vld),  32'd0);
    checkVal("midRst_result", mif.result,    32'd0);
    lastRes = '0;
    mif.start = 1'b0;
    rst_n = 1'b1;
    vldHits = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (mif.vld) vldHits++;
    end
    checkVal("midRst_noVld", 32'(vldHits), 32'd0);
    $display("[TB] mid-op reset: result=0x%08h vldHits=%0d", mif.result, vldHits);

    @(negedge clk);
    runMul(32'd4, 32'd4, "mul4x4");
    idleCheck("mul4x4");

    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
